clock_time_counter: RTL and testbench
=====================================

# clock_time_counter

Timekeeping stage of the digital clock. It divides the system clock down to a 1 Hz tick and maintains hours, minutes and seconds. It presents the time as a 14-bit binary HHMM value (hours × 100 + minutes, 0–2359) on `bin`, which feeds the top-level binary-to-BCD and 4-digit display path directly. It also provides two debounced-free set buttons and a colon-blink signal for the display's decimal point.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; prescaler period in cycles (≥ 4).
- `clk`  in  1  system clock; all state rises on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable; when low, prescaler and seconds are frozen.
- `btn_hr`  in  1  asynchronous level from board; each rising edge increments hours.
- `btn_min`  in  1  asynchronous level from board; each rising edge increments minutes.
- `bin`  out  14  registered HHMM binary value (hours × 100 + minutes).
- `colon`  out  1  registered blink signal for the DP between HH and MM.
- `sec_tick`  out  1  one-cycle pulse on every seconds advance.
- `pm`  out  1  registered PM flag; meaningful only in 12-hour mode, else 0.

## Operation
- Prescaler `pcnt` counts 0..CLK_HZ-1 while `en`=1, then wraps to 0. A tick is generated in the cycle where `pcnt`==CLK_HZ-1 and `en`=1.
- On a tick:
  - seconds 0..59 increment.
  - 59→0 carries into minutes 0..59.
  - 59→0 carries into hours 0..23.
  - 23:59:59 wraps to 00:00:00.
- Button path, per button:
  - 2-flop synchroniser, then a third flop for edge detection.
  - Press pulse = sync2 & ~sync3, one cycle wide.
  - No debounce in this block; bounces produce multiple increments.
- `btn_min` press:
  - minutes +1 mod 60, with no carry into hours.
  - seconds and `pcnt` are cleared to 0.
- `btn_hr` press: hours +1 mod 24; seconds and minutes are unaffected.
- Buttons act regardless of `en`.
- Simultaneous events:
  - A press in the same cycle as a tick wins: the tick is discarded and `sec_tick` stays 0.
  - Both presses in one cycle apply both: hours +1 and minutes +1, with seconds and `pcnt` cleared.
- Output register:
  - `bin` = Hd × 100 + M, computed as (Hd<<6)+(Hd<<5)+(Hd<<2)+M in 14 bits with no overflow (max 2359).
  - Hd is the displayed hour.
- `colon` = 1 when `en`=0. Otherwise it is 1 while `pcnt` < CLK_HZ/2 and 0 for the rest of the second.
- Reset (asynchronous, any time, including mid-count or mid-press):
  - `pcnt`, seconds, minutes, hours and all synchroniser flops clear to 0.
  - `bin`=0, `colon`=0, `sec_tick`=0, `pm`=0.
  - 12-hour mode exception: `bin`=1200 at reset (see Configuration).
- First press after reset: if the button is already high at reset release, it counts as one rising edge, since the sync flops clear to 0.

## Timing
- Tick latency: tick cycle T updates the counters at the posedge ending T. `sec_tick` is high in cycle T+1, and `bin`/`pm` reflect the new time in cycle T+2.
- Button latency: an input rising edge sampled at posedge N gives a press pulse in cycle N+2, counters updated at N+3, and `bin` updated at N+4.
- Seconds period: exactly CLK_HZ cycles between `sec_tick` pulses while `en`=1 and no `btn_min` press occurs.
- `en` deassertion freezes `pcnt` at its current value; reassertion resumes counting from that value.

## Configuration
- `CLOCK_12H_EN` defined:
  - Hd = (hours mod 12 == 0) ? 12 : hours mod 12.
  - `pm` = (hours ≥ 12).
  - `bin` range is 100..1259, with reset value 1200.
- Not defined:
  - Hd = hours (24-hour).
  - `pm` tied to 0.
  - `bin` range is 0..2359, with reset value 0.
- Internal hours always count 0..23 in both modes.

## Test plan
- Reset and run (CLK_HZ=10, `en`=1): `sec_tick` pulses every 10 cycles. After 600 cycles `bin`=1. `colon` is high 5 cycles and low 5 cycles per second.
- Wrap-around: preset via 23 `btn_hr` and 59 `btn_min` presses, then run 60 s. `bin` goes 2359→0, and hours/minutes/seconds all read 0.
- Press vs tick collision: assert a `btn_min` rising edge timed so its pulse lands on the tick cycle. Minutes +1, seconds=0, and no `sec_tick` that second.
- `en`=0 hold: freeze for 1000 cycles. `bin` unchanged, `colon`=1, no `sec_tick`. A `btn_hr` press still gives `bin` +100 at N+4.
- Async reset mid-count: assert `rst` between clock edges at time 12:34:56. All outputs are 0 immediately (1200 with `CLOCK_12H_EN`), before the next posedge.
- `CLOCK_12H_EN` build: hours 0 → `bin`=1200, `pm`=0. Hours 13, minutes 5 → `bin`=105, `pm`=1.

Source files
------------

// File: rtl/clock_time_counter.sv
// clock_time_counter: 1 Hz prescaler, HH:MM:SS counters, button set path and registered HHMM binary output.
// Define CLOCK_12H_EN for a 12-hour display (hours 12,1..11 plus pm flag); internal hours stay 0..23.

module clock_btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   // [0],[1] synchronise the async level, [2] holds the previous synced value for edge detect
   logic [2:0] sync_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[1:0], btn};

   assign press = sync_q[1] & ~sync_q[2];
endmodule

module clock_time_counter #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        btn_hr,
   input  logic        btn_min,
   output logic [13:0] bin,
   output logic        colon,
   output logic        sec_tick,
   output logic        pm
);
   localparam int            PW     = $clog2(CLK_HZ);
   localparam logic [PW-1:0] P_MAX  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
`ifdef CLOCK_12H_EN
   localparam logic [13:0]   BIN_RST = 14'd1200;
`else
   localparam logic [13:0]   BIN_RST = 14'd0;
`endif

   logic [1:0] btn_raw, btn_press;
   logic       hr_press, min_press;

   assign btn_raw = {btn_hr, btn_min};

   for (genvar i = 0; i < 2; i++) begin : g_btn
      clock_btn_sync u_sync (
         .clk   (clk),
         .rst   (rst),
         .btn   (btn_raw[i]),
         .press (btn_press[i])
      );
   end

   assign hr_press  = btn_press[1];
   assign min_press = btn_press[0];

   logic [PW-1:0] pcnt, pcnt_d;
   logic [5:0]    sec, sec_d, mins, mins_d;
   logic [4:0]    hrs, hrs_d;
   logic          tick, tick_ok;

   assign tick    = en && (pcnt == P_MAX);
   // any press in the tick cycle swallows that second
   assign tick_ok = tick && !hr_press && !min_press;

   always_comb begin
      pcnt_d = pcnt;
      sec_d  = sec;
      mins_d = mins;
      hrs_d  = hrs;
      if (en)
         pcnt_d = (pcnt == P_MAX) ? '0 : pcnt + 1'b1;
      if (tick_ok) begin
         if (sec == 6'd59) begin
            sec_d = '0;
            if (mins == 6'd59) begin
               mins_d = '0;
               hrs_d  = (hrs == 5'd23) ? '0 : hrs + 1'b1;
            end else begin
               mins_d = mins + 1'b1;
            end
         end else begin
            sec_d = sec + 1'b1;
         end
      end
      if (min_press) begin
         pcnt_d = '0;
         sec_d  = '0;
         mins_d = (mins == 6'd59) ? '0 : mins + 1'b1;
      end
      if (hr_press)
         hrs_d = (hrs == 5'd23) ? '0 : hrs + 1'b1;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pcnt <= '0;
         sec  <= '0;
         mins <= '0;
         hrs  <= '0;
      end else begin
         pcnt <= pcnt_d;
         sec  <= sec_d;
         mins <= mins_d;
         hrs  <= hrs_d;
      end

   logic [4:0]  hd;
   logic [13:0] hd14, bin_d;
   logic        pm_d;

   always_comb begin
`ifdef CLOCK_12H_EN
      if (hrs == 5'd0)       hd = 5'd12;
      else if (hrs > 5'd12)  hd = hrs - 5'd12;
      else                   hd = hrs;
      pm_d = (hrs >= 5'd12);
`else
      hd   = hrs;
      pm_d = 1'b0;
`endif
      hd14  = {9'd0, hd};
      // Hd*100 as shifts: 64+32+4
      bin_d = (hd14 << 6) + (hd14 << 5) + (hd14 << 2) + {8'd0, mins};
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bin      <= BIN_RST;
         colon    <= 1'b0;
         sec_tick <= 1'b0;
         pm       <= 1'b0;
      end else begin
         bin      <= bin_d;
         colon    <= !en || (pcnt < P_HALF);
         sec_tick <= tick_ok;
         pm       <= pm_d;
      end
endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter at CLK_HZ=10: table of preset vectors plus hand sequences.
`timescale 1ns/1ps
module tb_clock_time_counter;
   localparam int CLK_HZ = 10;
`ifdef CLOCK_12H_EN
   localparam int RST_BIN = 1200;
   localparam int H12     = 1;
`else
   localparam int RST_BIN = 0;
   localparam int H12     = 0;
`endif

   logic        clk = 1'b0, rst = 1'b1, en = 1'b0, btn_hr = 1'b0, btn_min = 1'b0;
   logic [13:0] bin;
   logic        colon, sec_tick, pm;
   int          errors = 0, checks = 0;

   clock_time_counter #(.CLK_HZ(CLK_HZ)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .btn_hr   (btn_hr),
      .btn_min  (btn_min),
      .bin      (bin),
      .colon    (colon),
      .sec_tick (sec_tick),
      .pm       (pm)
   );

   always #5 clk = ~clk;

   typedef struct { int hr; int mn; int exp_bin; int exp_pm; } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic h, input logic m);
      btn_hr = h; btn_min = m;
      step(4);
      btn_hr = 1'b0; btn_min = 1'b0;
      step(3);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   task automatic wait_ticks(input int n, input int bound, output int got);
      got = 0;
      for (int i = 0; i < bound && got < n; i++) begin
         step(1);
         if (sec_tick) got++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last, nticks, colon_hi, gap_bad, first, got, hold_ticks;
      logic [13:0] b;
      int pm12;
      pm12 = H12;

      // reset state
      step(2);
      check("rst_bin", int'(bin), RST_BIN);
      check("rst_colon", int'(colon), 0);
      check("rst_sec_tick", int'(sec_tick), 0);
      check("rst_pm", int'(pm), 0);

      // free run from reset
      rst = 1'b0; en = 1'b1;
      last = 0; nticks = 0; colon_hi = 0; gap_bad = 0;
      for (int n = 1; n <= 601; n++) begin
         step(1);
         if (n <= 600 && colon) colon_hi++;
         if (sec_tick) begin
            if (nticks == 0) check("first_tick", n, 10);
            else if (n - last != 10) gap_bad++;
            nticks++;
            last = n;
         end
         if (n == 600) check("bin_before_minute", int'(bin), RST_BIN);
      end
      check("tick_count", nticks, 60);
      check("tick_gaps", gap_bad, 0);
      check("colon_high_cycles", colon_hi, 300);
      check("bin_one_minute", int'(bin), RST_BIN + 1);

      // table of cumulative presses from 00:00 with the clock halted
      vecs[0] = '{1,  0,  100,                  0};
      vecs[1] = '{0,  5,  105,                  0};
      vecs[2] = '{11, 0,  1205,                 pm12};
      vecs[3] = '{1,  0,  (H12 != 0) ? 105  : 1305, pm12};
      vecs[4] = '{0,  55, (H12 != 0) ? 100  : 1300, pm12};
      vecs[5] = '{10, 0,  (H12 != 0) ? 1100 : 2300, pm12};
      vecs[6] = '{1,  0,  (H12 != 0) ? 1200 : 0,    0};
      en = 1'b0;
      do_reset();
      for (int v = 0; v < 7; v++) begin
         repeat (vecs[v].hr) press(1'b1, 1'b0);
         repeat (vecs[v].mn) press(1'b0, 1'b1);
         check($sformatf("vec%0d_bin", v), int'(bin), vecs[v].exp_bin);
         check($sformatf("vec%0d_pm", v), int'(pm), vecs[v].exp_pm);
      end

      // both buttons in one cycle: hours+1, minutes+1, prescaler restarted
      en = 1'b1;
      btn_hr = 1'b1; btn_min = 1'b1;
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         step(1);
         if (k == 3) check("both_bin_n3", int'(bin), RST_BIN);
         if (k == 4) check("both_bin_n4", int'(bin), 101);
         if (k >= 4 && sec_tick && first == 0) first = k;
      end
      check("both_next_tick", first, 13);
      btn_hr = 1'b0; btn_min = 1'b0;

      // btn_min pulse on the tick cycle: tick dropped, minute advanced
      wait_ticks(1, 40, got);
      check("collide_sync_tick", got, 1);
      step(7);
      btn_min = 1'b1;
      first = 0;
      for (int k = 1; k <= 15; k++) begin
         step(1);
         if (k == 4) check("collide_bin", int'(bin), 102);
         if (sec_tick && first == 0) first = k;
      end
      check("collide_first_tick", first, 13);
      btn_min = 1'b0;
      step(3);

      // wrap 23:59:59 -> 00:00:00
      en = 1'b0;
      do_reset();
      repeat (23) press(1'b1, 1'b0);
      repeat (59) press(1'b0, 1'b1);
      check("preset_2359_bin", int'(bin), (H12 != 0) ? 1159 : 2359);
      check("preset_2359_pm", int'(pm), pm12);
      en = 1'b1;
      wait_ticks(60, 700, got);
      check("wrap_ticks", got, 60);
      check("wrap_bin_before", int'(bin), (H12 != 0) ? 1159 : 2359);
      step(1);
      check("wrap_bin_after", int'(bin), RST_BIN);
      check("wrap_pm_after", int'(pm), 0);

      // en=0 hold
      en = 1'b0;
      step(2);
      b = bin;
      hold_ticks = 0;
      for (int k = 0; k < 1000; k++) begin
         step(1);
         if (sec_tick) hold_ticks++;
      end
      check("hold_no_ticks", hold_ticks, 0);
      check("hold_bin", int'(bin), int'(b));
      check("hold_colon", int'(colon), 1);
      btn_hr = 1'b1;
      step(3);
      check("hold_hr_n3", int'(bin), int'(b));
      step(1);
      check("hold_hr_n4", int'(bin), 100);
      btn_hr = 1'b0;
      step(3);

      // async reset at 12:34:56, between clock edges
      do_reset();
      repeat (12) press(1'b1, 1'b0);
      repeat (34) press(1'b0, 1'b1);
      en = 1'b1;
      wait_ticks(56, 700, got);
      check("pre_rst_ticks", got, 56);
      step(3);
      check("pre_rst_bin", int'(bin), 1234);
      check("pre_rst_pm", int'(pm), pm12);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_bin", int'(bin), RST_BIN);
      check("async_rst_colon", int'(colon), 0);
      check("async_rst_sec_tick", int'(sec_tick), 0);
      check("async_rst_pm", int'(pm), 0);
      step(2);
      rst = 1'b0;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
